// File: rtl/sram_rd_engine.sv
// Descriptor-driven read initiator for a banked SRAM port: issues one read per
// cycle under a credit check and streams the returned words out in order.
module sram_rd_engine #(
  parameter int DWIDTH     = 32,
  parameter int NRAMWIDTH  = 5,
  parameter int AWIDTH     = 13,
  parameter int LWIDTH     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        desc_valid_in,
  output logic                        desc_ready_out,
  input  logic [NRAMWIDTH+AWIDTH-1:0] desc_addr_in,
  input  logic [LWIDTH-1:0]           desc_len_in,
  output logic                        mem_en_out,
  output logic                        mem_we_out,
  output logic [NRAMWIDTH+AWIDTH-1:0] mem_addr_out,
  input  logic [DWIDTH-1:0]           mem_d_in,
  output logic                        rd_valid_out,
  input  logic                        rd_ready_in,
  output logic [DWIDTH-1:0]           rd_data_out,
  output logic                        rd_last_out,
  output logic                        busy_out,
  output logic                        done_out
);

  localparam int AW = NRAMWIDTH + AWIDTH;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cur_addr;
  logic [LWIDTH-1:0]   remaining;
  logic                inflight, inflight_last;
  logic [DWIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         occupancy;
  logic                done_q;
  logic                issue, accept, done_set, pop, head_last;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits: entries that stay in the FIFO this cycle plus the read whose data lands next edge.
  assign occupancy = (CW+1)'(count) - (CW+1)'(pop) + (CW+1)'(inflight);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    accept   = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (desc_valid_in) begin
          accept = 1'b1;
          if (desc_len_in == '0) done_set = 1'b1;
          else                   state_d  = RD;
        end
      end
      RD: begin
        if (occupancy < (CW+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remaining == LWIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= done_set;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LWIDTH'(1));
      if (accept) begin
        cur_addr  <= desc_addr_in;
        remaining <= desc_len_in;
      end else if (issue) begin
        cur_addr  <= cur_addr + AW'(1);
        remaining <= remaining - LWIDTH'(1);
      end
      if (inflight) wr_ptr <= ptr_next(wr_ptr);
      if (pop)      rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(inflight) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; the cleared pointers and count make stale contents unreachable.
  always_ff @(posedge clk_in) begin
    if (inflight) begin
      fifo_data[wr_ptr] <= mem_d_in;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  assign head_last      = fifo_last[rd_ptr];
  assign rd_valid_out   = (count != '0) && !rst_in;
  assign pop            = rd_valid_out && rd_ready_in;
  assign rd_data_out    = rd_valid_out ? fifo_data[rd_ptr] : '0;
  assign rd_last_out    = rd_valid_out && head_last;

  // Outputs are forced quiet while rst_in is high, whatever state the aborted run was in.
  assign mem_en_out     = issue && !rst_in;
  assign mem_we_out     = 1'b0;
  assign mem_addr_out   = mem_en_out ? cur_addr : '0;
  assign desc_ready_out = (state_q == IDLE) && !rst_in;
  assign busy_out       = (state_q != IDLE) && !rst_in;
  assign done_out       = done_q && !rst_in;

endmodule

// File: tb/tb_sram_rd_engine.sv
// Directed bench for sram_rd_engine: SRAM model with 1-cycle latency, address and
// beat scoreboards filled when descriptors are driven, cycle-accurate timing checks.
module tb_sram_rd_engine;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        desc_valid_in = 1'b0;
  logic        desc_ready_out;
  logic [17:0] desc_addr_in = '0;
  logic [9:0]  desc_len_in = '0;
  logic        mem_en_out, mem_we_out;
  logic [17:0] mem_addr_out;
  logic [31:0] mem_d_in = '0;
  logic        rd_valid_out;
  logic        rd_ready_in = 1'b1;
  logic [31:0] rd_data_out;
  logic        rd_last_out, busy_out, done_out;

  sram_rd_engine dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .desc_valid_in(desc_valid_in), .desc_ready_out(desc_ready_out),
    .desc_addr_in(desc_addr_in), .desc_len_in(desc_len_in),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_d_in(mem_d_in),
    .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
    .rd_data_out(rd_data_out), .rd_last_out(rd_last_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc++;

  function automatic logic [31:0] sram_word(input logic [17:0] a);
    return {a[13:0] ^ 14'h2c5b, a};
  endfunction

  always @(posedge clk_in) if (mem_en_out) mem_d_in <= sram_word(mem_addr_out);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [17:0] exp_addr[$];
  logic [32:0] exp_beat[$];
  int en_count, first_en, last_en, beats, first_beat, last_beat, done_cnt;
  logic busy_seen;
  logic prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  task automatic clear_stats();
    en_count = 0; first_en = -1; last_en = -1;
    beats = 0; first_beat = -1; last_beat = -1;
    done_cnt = 0; busy_seen = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (mem_en_out) begin
      en_count++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      check("issue_expected", 64'(exp_addr.size() > 0), 1);
      if (exp_addr.size() > 0) check("mem_addr", mem_addr_out, exp_addr.pop_front());
    end
    if (prev_stall) begin
      check("stall_valid", rd_valid_out, 1);
      check("stall_word", {rd_last_out, rd_data_out}, prev_word);
    end
    if (rd_valid_out && rd_ready_in) begin
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      check("beat_expected", 64'(exp_beat.size() > 0), 1);
      if (exp_beat.size() > 0) check("beat_word", {rd_last_out, rd_data_out}, exp_beat.pop_front());
    end
    if (done_out) done_cnt++;
    if (busy_out) busy_seen = 1'b1;
    prev_stall = rd_valid_out && !rd_ready_in;
    prev_word  = {rd_last_out, rd_data_out};
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Presents a descriptor, fills both scoreboards, returns the handshake cycle.
  task automatic send(input logic [17:0] a, input logic [9:0] n, output int t);
    desc_addr_in  = a;
    desc_len_in   = n;
    desc_valid_in = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(a + 18'(i));
      exp_beat.push_back({i == int'(n) - 1, sram_word(a + 18'(i))});
    end
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      @(negedge clk_in);
      if (desc_ready_out) t = cyc;
    end
    check("desc_accept", 64'(t >= 0), 1);
    @(posedge clk_in);
    #1;
    desc_valid_in = 1'b0;
  endtask

  // Returns the cycle in which done_out is high, polled just after each edge.
  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget && d < 0; i++) begin
      if (done_out) d = cyc;
      else begin
        @(posedge clk_in);
        #1;
      end
    end
    check("done_seen", 64'(d >= 0), 1);
  endtask

  initial begin
    int t, t2, d;
    clear_stats();

    // Reset values during rst_in and in the cycle after release.
    @(negedge clk_in);
    check("rst_outputs", {mem_en_out, mem_we_out, mem_addr_out, rd_valid_out, rd_data_out,
                          rd_last_out, busy_out, done_out, desc_ready_out}, '0);
    step(1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_outputs", {mem_en_out, mem_we_out, mem_addr_out, rd_valid_out, rd_data_out,
                               rd_last_out, busy_out, done_out}, '0);
    check("post_rst_ready", desc_ready_out, 1);
    step(1);

    // Bank crossing with ready high.
    clear_stats();
    send(18'h01FFE, 10'd4, t);
    wait_done(40, d);
    check("t1_done_cyc", d, t + 7);
    check("t1_first_en", first_en, t + 1);
    check("t1_last_en", last_en, t + 4);
    check("t1_en_count", en_count, 4);
    check("t1_first_beat", first_beat, t + 3);
    check("t1_last_beat", last_beat, t + 6);
    check("t1_beats", beats, 4);
    check("t1_busy_seen", busy_seen, 1);
    step(2);
    check("t1_done_once", done_cnt, 1);

    // Backpressure: ready low for 20 cycles.
    clear_stats();
    rd_ready_in = 1'b0;
    send(18'h00400, 10'd16, t);
    step(20);
    check("t2_en_stall", en_count, 4);
    check("t2_beats_stall", beats, 0);
    rd_ready_in = 1'b1;
    wait_done(100, d);
    check("t2_en_count", en_count, 16);
    check("t2_beats", beats, 16);
    check("t2_beat_q_empty", exp_beat.size(), 0);

    // Zero length.
    step(1);
    clear_stats();
    send(18'h00123, 10'd0, t);
    wait_done(10, d);
    check("t3_done_cyc", d, t + 1);
    step(4);
    check("t3_en_count", en_count, 0);
    check("t3_beats", beats, 0);
    check("t3_busy_seen", busy_seen, 0);
    check("t3_done_once", done_cnt, 1);

    // Address wrap.
    clear_stats();
    send(18'h3FFFF, 10'd2, t);
    wait_done(20, d);
    check("t4_beats", beats, 2);
    check("t4_en_count", en_count, 2);

    // Reset after three beats of a ten-word descriptor.
    step(1);
    clear_stats();
    send(18'h00200, 10'd10, t);
    for (int i = 0; i < 30 && beats < 3; i++) step(1);
    check("t5_three_beats", beats, 3);
    rst_in = 1'b1;
    exp_addr.delete();
    exp_beat.delete();
    clear_stats();
    @(negedge clk_in);
    check("t5_rst_cycle", {rd_valid_out, mem_en_out, done_out, busy_out, desc_ready_out}, '0);
    step(1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("t5_after_rst", {rd_valid_out, mem_en_out, done_out, busy_out}, '0);
    check("t5_ready_back", desc_ready_out, 1);
    step(5);
    check("t5_no_done", done_cnt, 0);
    check("t5_no_beats", beats, 0);
    send(18'h00100, 10'd2, t);
    wait_done(20, d);
    check("t5_new_done_cyc", d, t + 5);
    check("t5_new_beats", beats, 2);

    // Throughput, then a back-to-back descriptor on the done cycle.
    step(1);
    clear_stats();
    send(18'h20000, 10'd64, t);
    wait_done(120, d);
    check("t6_done_cyc", d, t + 67);
    check("t6_first_beat", first_beat, t + 3);
    check("t6_last_beat", last_beat, t + 66);
    check("t6_beats", beats, 64);
    clear_stats();
    send(18'h00050, 10'd3, t2);
    check("t6_b2b_accept", t2, d);
    wait_done(30, d);
    check("t6_b2b_beats", beats, 3);

    step(2);
    check("end_addr_q_empty", exp_addr.size(), 0);
    check("end_beat_q_empty", exp_beat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
